lsu_queue: RTL and testbench

LSU_QUEUE -- requirements
Module: lsu_queue

---
 rtl/lsu_queue.sv | 122 ++++++++++++
 tb/tb_lsu_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_queue.sv
// In-order load/store queue: forwards requests to data memory and tags each one, so responses can be steered to writeback or dropped.
// Optional macro LSU_BYTE_SIGN_EXT_EN: byte loads sign-extend instead of zero-extend.
module lsu_queue #(
  parameter int DEPTH_P      = 4,
  parameter int DATA_WIDTH_P = 32,
  parameter int RD_WIDTH_P   = 5,
  localparam int PTR_W       = $clog2(DEPTH_P),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid_i,
  input  logic                    req_wen_i,
  input  logic                    req_byte_i,
  input  logic [DATA_WIDTH_P-1:0] req_addr_i,
  input  logic [DATA_WIDTH_P-1:0] req_wdata_i,
  input  logic [RD_WIDTH_P-1:0]   req_rd_i,
  output logic                    req_accept_o,
  output logic                    mem_valid_o,
  output logic [DATA_WIDTH_P-1:0] mem_addr_o,
  output logic [DATA_WIDTH_P-1:0] mem_wdata_o,
  output logic                    mem_wen_o,
  output logic                    mem_byte_o,
  input  logic                    mem_yumi_i,
  input  logic                    mem_resp_valid_i,
  input  logic [DATA_WIDTH_P-1:0] mem_rdata_i,
  output logic                    mem_resp_yumi_o,
  output logic                    wb_valid_o,
  output logic [RD_WIDTH_P-1:0]   wb_rd_o,
  output logic [DATA_WIDTH_P-1:0] wb_data_o,
  input  logic                    wb_ready_i,
  output logic [CNT_W-1:0]        count_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    err_o
);

  typedef struct packed {
    logic                  wen;
    logic                  byte_op;
    logic [RD_WIDTH_P-1:0] rd;
    logic [1:0]            off;
  } tag_t;

  tag_t             tags [DEPTH_P];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             err;
  logic             push, pop;
  tag_t             head;
  logic [7:0]       sel_byte;

  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH_P));
  assign count_o = count;
  assign err_o   = err;

  // Request path is pure pass-through; full blocks regardless of a same-cycle pop.
  assign mem_valid_o  = req_valid_i & ~full_o;
  assign mem_addr_o   = req_addr_i;
  assign mem_wdata_o  = req_wdata_i;
  assign mem_wen_o    = req_wen_i;
  assign mem_byte_o   = req_byte_i;
  assign req_accept_o = mem_valid_o & mem_yumi_i;
  assign push         = req_accept_o;

  assign head = tags[rptr];

  always_comb begin
    wb_valid_o      = 1'b0;
    mem_resp_yumi_o = 1'b0;
    pop             = 1'b0;
    if (empty_o) begin
      // Orphan response: consume and drop it, flagged via err.
      mem_resp_yumi_o = mem_resp_valid_i;
    end else if (head.wen) begin
      mem_resp_yumi_o = mem_resp_valid_i;
      pop             = mem_resp_valid_i;
    end else begin
      wb_valid_o      = mem_resp_valid_i;
      mem_resp_yumi_o = mem_resp_valid_i & wb_ready_i;
      pop             = mem_resp_valid_i & wb_ready_i;
    end
  end

  always_comb begin
    sel_byte = mem_rdata_i[7:0];
    case (head.off)
      2'd1:    sel_byte = mem_rdata_i[15:8];
      2'd2:    sel_byte = mem_rdata_i[23:16];
      2'd3:    sel_byte = mem_rdata_i[31:24];
      default: sel_byte = mem_rdata_i[7:0];
    endcase
  end

  assign wb_rd_o = head.rd;
`ifdef LSU_BYTE_SIGN_EXT_EN
  assign wb_data_o = head.byte_op ? {{(DATA_WIDTH_P-8){sel_byte[7]}}, sel_byte} : mem_rdata_i;
`else
  assign wb_data_o = head.byte_op ? {{(DATA_WIDTH_P-8){1'b0}}, sel_byte} : mem_rdata_i;
`endif

  always_ff @(posedge clk) begin
    if (push) tags[wptr] <= '{wen: req_wen_i, byte_op: req_byte_i, rd: req_rd_i, off: req_addr_i[1:0]};
  end

  // Pointers wrap naturally since DEPTH_P is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (mem_resp_valid_i && empty_o) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_queue.sv
// Directed plus random checks of lsu_queue against a queue-based reference model.
module tb_lsu_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_wen, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        req_accept, mem_valid, mem_wen, mem_byte, mem_yumi;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_resp_valid, mem_resp_yumi;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  count;
  logic        empty, full, err;

  lsu_queue #(.DEPTH_P(DEPTH), .DATA_WIDTH_P(32), .RD_WIDTH_P(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_wen_i(req_wen), .req_byte_i(req_byte),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .req_accept_o(req_accept), .mem_valid_o(mem_valid), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wen_o(mem_wen), .mem_byte_o(mem_byte),
    .mem_yumi_i(mem_yumi), .mem_resp_valid_i(mem_resp_valid), .mem_rdata_i(mem_rdata),
    .mem_resp_yumi_o(mem_resp_yumi), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .wb_ready_i(wb_ready), .count_o(count),
    .empty_o(empty), .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {bit wen; bit bt; int rd; int off;} mtag_t;
  mtag_t q[$];
  bit    m_err, m_err_set, m_push, m_pop;
  mtag_t m_tag;
  int    total = 0, passed = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_data(mtag_t t, logic [31:0] d);
    logic [31:0] b;
    if (!t.bt) return d;
    b = (d >> (8 * t.off)) & 32'hFF;
`ifdef LSU_BYTE_SIGN_EXT_EN
    if (b >= 32'h80) b = b + 32'hFFFFFF00;
`endif
    return b;
  endfunction

  // Expected outputs derived from the queue contents and current inputs.
  task automatic model_check();
    bit ef, emv, eacc, ewb, eyumi;
    ef   = (q.size() == DEPTH);
    emv  = req_valid && !ef;
    eacc = emv && mem_yumi;
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, ef);
    check("err", err, m_err);
    check("mem_valid", mem_valid, emv);
    check("req_accept", req_accept, eacc);
    if (emv) begin
      check("mem_addr", mem_addr, req_addr);
      check("mem_wdata", mem_wdata, req_wdata);
      check("mem_wen", mem_wen, req_wen);
      check("mem_byte", mem_byte, req_byte);
    end
    ewb = 0; eyumi = 0; m_pop = 0; m_err_set = 0;
    if (q.size() == 0) begin
      eyumi = mem_resp_valid;
      m_err_set = mem_resp_valid;
    end else if (q[0].wen) begin
      eyumi = mem_resp_valid;
      m_pop = mem_resp_valid;
    end else begin
      ewb   = mem_resp_valid;
      eyumi = mem_resp_valid && wb_ready;
      m_pop = eyumi;
      if (ewb) begin
        check("wb_rd", wb_rd, q[0].rd);
        check("wb_data", wb_data, ref_data(q[0], mem_rdata));
      end
    end
    check("wb_valid", wb_valid, ewb);
    check("resp_yumi", mem_resp_yumi, eyumi);
    m_push = eacc;
    m_tag  = '{wen: req_wen, bt: req_byte, rd: int'(req_rd), off: int'(req_addr[1:0])};
  endtask

  task automatic step(bit rv, bit w, bit b, logic [31:0] a, logic [31:0] wd, int rd,
                      bit y, bit rsv, logic [31:0] rdt, bit rdy);
    req_valid = rv; req_wen = w; req_byte = b; req_addr = a; req_wdata = wd;
    req_rd = rd[4:0]; mem_yumi = y; mem_resp_valid = rsv; mem_rdata = rdt; wb_ready = rdy;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_pop) void'(q.pop_front());
    if (m_push) q.push_back(m_tag);
    if (m_err_set) m_err = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] exp_b;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic load with response two cycles later.
    step(1, 0, 0, 32'h10, 0, 3, 1, 0, 0, 1); tick();
    idle(); tick();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1);
    check("l1_wbv", wb_valid, 1);
    check("l1_rd", wb_rd, 3);
    check("l1_data", wb_data, 32'hDEADBEEF);
    tick();
    idle(); check("l1_cnt", count, 0);

    // Fill to DEPTH, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 32'h100 + 4 * i, 0, i + 1, 1, 0, 0, 1); tick();
    end
    step(1, 0, 0, 32'h200, 0, 9, 1, 0, 0, 1);
    check("fill_full", full, 1);
    check("fill_mv", mem_valid, 0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1000 + i, 1);
      check("drain_rd", wb_rd, i + 1);
      tick();
    end

    // Byte load from the top byte.
    step(1, 0, 1, 32'h3, 0, 7, 1, 0, 0, 1); tick();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FFFFFF, 1);
`ifdef LSU_BYTE_SIGN_EXT_EN
    exp_b = 32'hFFFFFF80;
`else
    exp_b = 32'h00000080;
`endif
    check("byte_data", wb_data, exp_b);
    tick();

    // Writeback stall holds the response.
    step(1, 0, 0, 32'h20, 0, 9, 1, 0, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0);
      check("stall_yumi", mem_resp_yumi, 0);
      check("stall_cnt", count, 1);
      tick();
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 1);
    check("rel_wbv", wb_valid, 1);
    check("rel_yumi", mem_resp_yumi, 1);
    tick();
    idle(); check("rel_cnt", count, 0);

    // Store then load.
    step(1, 1, 0, 32'h30, 32'hCAFE, 0, 1, 0, 0, 1); tick();
    step(1, 0, 0, 32'h34, 0, 5, 1, 0, 0, 1); tick();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1);
    check("st_cnt2", count, 2);
    check("st_wbv", wb_valid, 0);
    check("st_yumi", mem_resp_yumi, 1);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 1);
    check("ld_cnt1", count, 1);
    check("ld_rd", wb_rd, 5);
    tick();
    idle(); check("ld_cnt0", count, 0);

    // Orphan response, then async reset with three outstanding.
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 1);
    check("orph_yumi", mem_resp_yumi, 1);
    check("orph_wbv", wb_valid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 32'h40, 0, i, 1, 0, 0, 1);
      check("sticky_err", err, 1);
      tick();
    end
    idle(); check("pre_rst_cnt", count, 3);
    #2 reset = 1'b0;
    #1;
    check("arst_cnt", count, 0);
    check("arst_err", err, 0);
    check("arst_empty", empty, 1);
    q.delete(); m_err = 0;
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 1);
    check("post_rst_wbv", wb_valid, 0);
    tick();
    idle(); check("post_rst_err", err, 1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      bit rsv;
      rsv = (q.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom, $urandom, $urandom_range(0, 31), $urandom_range(0, 3) != 0,
           rsv, $urandom, $urandom_range(0, 9) < 7);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
